// File: rtl/rtc_edit_pkg.sv
// Shared constants, types and range helpers for the RTC field editor.
// Field values are 7-bit binary; hour range depends on 12/24 h format.
package rtc_edit_pkg;

  localparam int W = 7;
  typedef logic [W-1:0] val_t;

  typedef enum logic [2:0] {
    F_SEC   = 3'd0,
    F_MIN   = 3'd1,
    F_HOUR  = 3'd2,
    F_DAY   = 3'd3,
    F_MONTH = 3'd4,
    F_YEAR  = 3'd5
  } field_e;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CONV,
    ACT_UP,
    ACT_DN,
    ACT_RIGHT,
    ACT_LEFT
  } act_e;

  localparam val_t SEC_MIN    = 7'd0;
  localparam val_t SEC_MAX    = 7'd59;
  localparam val_t MIN_MIN    = 7'd0;
  localparam val_t MIN_MAX    = 7'd59;
  localparam val_t HOUR_MIN   = 7'd0;
  localparam val_t HOUR_MAX   = 7'd23;
  localparam val_t HOUR12_MIN = 7'd1;
  localparam val_t HOUR12_MAX = 7'd12;
  localparam val_t DAY_MIN    = 7'd1;
  localparam val_t DAY_MAX    = 7'd31;
  localparam val_t MONTH_MIN  = 7'd1;
  localparam val_t MONTH_MAX  = 7'd12;
  localparam val_t YEAR_MIN   = 7'd0;
  localparam val_t YEAR_MAX   = 7'd99;

  function automatic val_t fmin(field_e f, logic h12);
    case (f)
      F_SEC:   return SEC_MIN;
      F_MIN:   return MIN_MIN;
      F_HOUR:  return h12 ? HOUR12_MIN : HOUR_MIN;
      F_DAY:   return DAY_MIN;
      F_MONTH: return MONTH_MIN;
      default: return YEAR_MIN;
    endcase
  endfunction

  function automatic val_t fmax(field_e f, logic h12);
    case (f)
      F_SEC:   return SEC_MAX;
      F_MIN:   return MIN_MAX;
      F_HOUR:  return h12 ? HOUR12_MAX : HOUR_MAX;
      F_DAY:   return DAY_MAX;
      F_MONTH: return MONTH_MAX;
      default: return YEAR_MAX;
    endcase
  endfunction

endpackage

// File: rtl/rtc_field_editor_if.sv
// Button/format inputs and decoder-facing outputs of the field editor.
// master drives buttons and format; slave is the editor itself.
interface rtc_field_editor_if;
  import rtc_edit_pkg::*;

  logic       edit_en;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       SF_24_12;
  val_t       Wr_bin;
  logic [2:0] field_sel;
  logic       sel_hora;
  logic       SF_AM_PM;
  logic       wr_req;

  modport master (
    output edit_en, btn_up, btn_down,
    output btn_left, btn_right, SF_24_12,
    input  Wr_bin, field_sel, sel_hora,
    input  SF_AM_PM, wr_req
  );

  modport slave (
    input  edit_en, btn_up, btn_down,
    input  btn_left, btn_right, SF_24_12,
    output Wr_bin, field_sel, sel_hora,
    output SF_AM_PM, wr_req
  );
endinterface

// File: rtl/btn_edge_det.sv
// Rising-edge detector for one debounced button level.
// A held button yields one pulse; a low sample re-arms it.
module btn_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);
  logic prev_q, prev_d;

  always_comb prev_d = btn;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= prev_d;
  end

  assign rise = btn & ~prev_q;
endmodule

// File: rtl/rtc_field_editor.sv
// RTC time/date field editor: six fields, button edits, 12/24 h
// conversion and a one-cycle write request toward the BCD decoder.
module rtc_field_editor
  import rtc_edit_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  rtc_field_editor_if.slave   bus
);
  logic   up_e, dn_e, lf_e, rt_e;
  val_t   fld_q [6];
  val_t   fld_d [6];
  field_e sel_q, sel_d;
  logic   fmt_q, fmt_d;
  logic   ampm_q, ampm_d;
  logic   wr_req_q, wr_req_d;
  act_e   act;
  val_t   cur, lo, hi, hr;

  btn_edge_det u_up (
    .clk(clk), .reset(reset),
    .btn(bus.btn_up), .rise(up_e)
  );
  btn_edge_det u_dn (
    .clk(clk), .reset(reset),
    .btn(bus.btn_down), .rise(dn_e)
  );
  btn_edge_det u_lf (
    .clk(clk), .reset(reset),
    .btn(bus.btn_left), .rise(lf_e)
  );
  btn_edge_det u_rt (
    .clk(clk), .reset(reset),
    .btn(bus.btn_right), .rise(rt_e)
  );

  // Simultaneous up+down cancel each other but not left/right.
  always_comb begin
    act = ACT_NONE;
    if (bus.SF_24_12 != fmt_q)  act = ACT_CONV;
    else if (!bus.edit_en)      act = ACT_NONE;
    else if (up_e && !dn_e)     act = ACT_UP;
    else if (dn_e && !up_e)     act = ACT_DN;
    else if (rt_e)              act = ACT_RIGHT;
    else if (lf_e)              act = ACT_LEFT;
  end

  always_comb begin
    fld_d    = fld_q;
    sel_d    = sel_q;
    fmt_d    = fmt_q;
    ampm_d   = ampm_q;
    wr_req_d = 1'b0;
    cur      = fld_q[sel_q];
    lo       = fmin(sel_q, fmt_q);
    hi       = fmax(sel_q, fmt_q);
    hr       = fld_q[F_HOUR];
    unique case (act)
      ACT_CONV: begin
        fmt_d    = bus.SF_24_12;
        sel_d    = F_HOUR;
        wr_req_d = bus.edit_en;
        if (bus.SF_24_12) begin
          ampm_d = (hr >= 7'd12);
          if (hr == 7'd0)
            fld_d[F_HOUR] = 7'd12;
          else if (hr > 7'd12)
            fld_d[F_HOUR] = val_t'(hr - 7'd12);
        end else begin
          if (hr == 7'd12)
            fld_d[F_HOUR] = ampm_q ? 7'd12 : 7'd0;
          else if (ampm_q)
            fld_d[F_HOUR] = val_t'(hr + 7'd12);
        end
      end
      ACT_UP: begin
        fld_d[sel_q] = (cur == hi) ? lo : val_t'(cur + 7'd1);
        if (sel_q == F_HOUR && fmt_q && cur == 7'd11)
          ampm_d = ~ampm_q;
        wr_req_d = 1'b1;
      end
      ACT_DN: begin
        fld_d[sel_q] = (cur == lo) ? hi : val_t'(cur - 7'd1);
        if (sel_q == F_HOUR && fmt_q && cur == 7'd12)
          ampm_d = ~ampm_q;
        wr_req_d = 1'b1;
      end
      ACT_RIGHT: begin
        sel_d = (sel_q == F_YEAR) ? F_SEC
                                  : field_e'(sel_q + 3'd1);
      end
      ACT_LEFT: begin
        sel_d = (sel_q == F_SEC) ? F_YEAR
                                 : field_e'(sel_q - 3'd1);
      end
      default: ;
    endcase
    if (!fmt_d) ampm_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 6; i++)
        fld_q[i] <= fmin(field_e'(i), 1'b0);
      sel_q    <= F_SEC;
      fmt_q    <= 1'b0;
      ampm_q   <= 1'b0;
      wr_req_q <= 1'b0;
    end else begin
      fld_q    <= fld_d;
      sel_q    <= sel_d;
      fmt_q    <= fmt_d;
      ampm_q   <= ampm_d;
      wr_req_q <= wr_req_d;
    end
  end

  assign bus.Wr_bin    = fld_q[sel_q];
  assign bus.field_sel = sel_q;
  assign bus.sel_hora  = (sel_q == F_HOUR);
  assign bus.SF_AM_PM  = ampm_q;
  assign bus.wr_req    = wr_req_q;
endmodule

// File: tb/tb_rtc_field_editor.sv
// Bench for rtc_field_editor: directed scenarios plus random buttons,
// checked against a model that keeps the hour as canonical 0..23.
module tb_rtc_field_editor;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rtc_field_editor_if bus ();

  rtc_field_editor dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;

  int  m_fld [6];
  int  m_h24;
  bit  m_fmt;
  int  m_sel;
  bit  m_prev [4];
  bit  m_wr;
  int  lo_t [6] = '{0, 0, 0, 1, 1, 0};
  int  hi_t [6] = '{59, 59, 23, 31, 12, 99};

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_bin();
    if (m_sel != 2) return m_fld[m_sel];
    if (!m_fmt) return m_h24;
    return (m_h24 % 12 == 0) ? 12 : m_h24 % 12;
  endfunction

  task automatic model_reset();
    m_fld = '{0, 0, 0, 1, 1, 0};
    m_h24 = 0;
    m_fmt = 0;
    m_sel = 0;
    m_wr  = 0;
    for (int i = 0; i < 4; i++) m_prev[i] = 0;
  endtask

  // Hour moves on the 24 h circle in both formats; the 12 h view
  // and its AM/PM flag are derived from it.
  task automatic model_step();
    bit b [4];
    bit e [4];
    b[0] = bus.btn_up;
    b[1] = bus.btn_down;
    b[2] = bus.btn_right;
    b[3] = bus.btn_left;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      e[i] = b[i] & ~m_prev[i];
      m_prev[i] = b[i];
    end
    m_wr = 0;
    if (bus.SF_24_12 != m_fmt) begin
      m_fmt = bus.SF_24_12;
      m_sel = 2;
      m_wr  = bus.edit_en;
    end else if (bus.edit_en) begin
      if (e[0] != e[1]) begin
        m_wr = 1;
        if (m_sel == 2)
          m_h24 = (m_h24 + (e[0] ? 1 : 23)) % 24;
        else if (e[0])
          m_fld[m_sel] = (m_fld[m_sel] == hi_t[m_sel]) ?
                         lo_t[m_sel] : m_fld[m_sel] + 1;
        else
          m_fld[m_sel] = (m_fld[m_sel] == lo_t[m_sel]) ?
                         hi_t[m_sel] : m_fld[m_sel] - 1;
      end else if (e[2]) begin
        m_sel = (m_sel + 1) % 6;
      end else if (e[3]) begin
        m_sel = (m_sel + 5) % 6;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("wr_bin", bus.Wr_bin, exp_bin());
    chk("field_sel", bus.field_sel, m_sel);
    chk("sel_hora", bus.sel_hora, m_sel == 2);
    chk("am_pm", bus.SF_AM_PM, m_fmt && m_h24 >= 12);
    chk("wr_req", bus.wr_req, m_wr);
    if (bus.wr_req) wr_cnt++;
  endtask

  task automatic set_btn(int idx, logic v);
    case (idx)
      0: bus.btn_up = v;
      1: bus.btn_down = v;
      2: bus.btn_right = v;
      default: bus.btn_left = v;
    endcase
  endtask

  task automatic press(int idx);
    set_btn(idx, 1'b1);
    step();
    set_btn(idx, 1'b0);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    bus.edit_en   = 1'b1;
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.SF_24_12  = 1'b0;
    model_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_bin", bus.Wr_bin, 0);
    chk("rst_sel", bus.field_sel, 0);
    chk("rst_wr", bus.wr_req, 0);

    wr_cnt = 0;
    repeat (60) press(0);
    chk("sec_wr_cnt", wr_cnt, 60);
    chk("sec_wrap", bus.Wr_bin, 0);

    press(2);
    press(2);
    press(1);
    chk("hr_23", bus.Wr_bin, 23);
    press(0);
    chk("hr_wrap", bus.Wr_bin, 0);
    chk("hr_sel", bus.sel_hora, 1);

    repeat (13) press(0);
    bus.SF_24_12 = 1'b1;
    wr_cnt = 0;
    step();
    chk("to12_hr", bus.Wr_bin, 1);
    chk("to12_pm", bus.SF_AM_PM, 1);
    step();
    chk("to12_wr", wr_cnt, 1);
    repeat (2) press(1);
    chk("h11am", bus.Wr_bin, 11);
    chk("h11am_pm", bus.SF_AM_PM, 0);
    press(0);
    chk("h12pm_pm", bus.SF_AM_PM, 1);
    press(0);
    chk("h1pm", bus.Wr_bin, 1);
    repeat (2) press(1);
    chk("h11am2", bus.SF_AM_PM, 0);
    repeat (2) press(0);
    bus.SF_24_12 = 1'b0;
    step();
    chk("to24_hr", bus.Wr_bin, 13);

    press(2);
    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    step();
    chk("ud_wr", bus.wr_req, 0);
    chk("ud_day", bus.Wr_bin, 1);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    step();

    bus.edit_en = 1'b0;
    wr_cnt = 0;
    repeat (3) press(0);
    chk("dis_wr", wr_cnt, 0);
    bus.edit_en = 1'b1;

    bus.btn_up = 1'b1;
    do_reset();
    chk("rst_mid_wr", bus.wr_req, 0);
    chk("rst_mid_sel", bus.field_sel, 0);
    bus.btn_up = 1'b0;
    step();
    press(3);
    chk("left_wrap", bus.field_sel, 5);

    bus.SF_24_12 = 1'b1;
    do_reset();
    step();
    chk("rst12_hr", bus.Wr_bin, 12);
    chk("rst12_sel", bus.field_sel, 2);

    for (int n = 0; n < 3000; n++) begin
      bus.btn_up    = ($urandom_range(3) == 0);
      bus.btn_down  = ($urandom_range(3) == 0);
      bus.btn_right = ($urandom_range(5) == 0);
      bus.btn_left  = ($urandom_range(5) == 0);
      bus.edit_en   = ($urandom_range(9) != 0);
      if ($urandom_range(49) == 0)
        bus.SF_24_12 = ~bus.SF_24_12;
      reset = ($urandom_range(99) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
